// File: rtl/serdes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serdes_pkg
// Description : Shared symbol constants and transmit FSM state encoding for
//               the serdes link (serializador / deserializador).
// Revision    : 1.0 - initial release
// ============================================================================
package serdes_pkg;

    // Special symbols, identical on transmit and receive sides
    localparam logic [7:0] STP = 8'hfb;
    localparam logic [7:0] SDP = 8'h5c;
    localparam logic [7:0] END = 8'hfd;
    localparam logic [7:0] EDB = 8'hfe;
    localparam logic [7:0] SKP = 8'h1c;
    localparam logic [7:0] IDL = 8'h7c;
    localparam logic [7:0] FTS = 8'h3c;
    localparam logic [7:0] COM = 8'hbc;

    // Symbol-source FSM: normal traffic plus the four slots of an ordered set
    typedef enum logic [2:0] {
        SYM     = 3'd0,
        SKP_COM = 3'd1,
        SKP_1   = 3'd2,
        SKP_2   = 3'd3,
        SKP_3   = 3'd4
    } serdes_state_e;

    // Increment that sticks at a ceiling instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] val,
                                              input logic [15:0] ceil);
        return (val >= ceil) ? ceil : (val + 16'd1);
    endfunction

endpackage : serdes_pkg
`default_nettype wire

// File: rtl/serdes_shift_out.sv
`default_nettype none
// ============================================================================
// Module      : serdes_shift_out
// Description : 8-bit parallel-load, MSB-first shift register with the slot
//               bit counter. Loads a new symbol on every slot boundary
//               (bit_cnt == 7) and flags the cycle carrying bit 7.
// Revision    : 1.0 - initial release
// ============================================================================
module serdes_shift_out (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] load_data_i,
    input  logic       load_dk_i,
    output logic       boundary_o,
    output logic       data_o,
    output logic       dk_o,
    output logic       sym_start_o
);

    logic [2:0] bit_cnt_q;
    logic [7:0] shreg_q;
    logic       dk_q;

    // Boundary is the last bit of the current slot; next symbol loads here
    assign boundary_o  = (bit_cnt_q == 3'd7);
    assign data_o      = shreg_q[7];
    assign dk_o        = dk_q;
    // bit_cnt only reaches 0 after a load, so this stays low out of reset
    assign sym_start_o = (bit_cnt_q == 3'd0);

    // Free-running slot counter, load on boundary, otherwise shift left
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_q <= 3'd7;
            shreg_q   <= 8'd0;
            dk_q      <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (boundary_o) begin
                shreg_q <= load_data_i;
                dk_q    <= load_dk_i;
            end else begin
                shreg_q <= {shreg_q[6:0], 1'b0};
            end
        end
    end

endmodule : serdes_shift_out
`default_nettype wire

// File: rtl/serializador.sv
`default_nettype none
// ============================================================================
// Module      : serializador
// Description : Transmit-side serializer. Accepts one symbol + K flag per
//               8-cycle slot via valid/ready, sends it MSB first, fills idle
//               slots with IDL. With SERDES_SKP_INSERT_EN defined, inserts a
//               COM,SKP,SKP,SKP ordered set every SKP_INTERVAL symbols.
// Macro       : SERDES_SKP_INSERT_EN (optional SKP ordered-set insertion)
// Revision    : 1.0 - initial release
// ============================================================================
module serializador
    import serdes_pkg::*;
#(
    parameter int unsigned SKP_INTERVAL = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_DK,
    output logic       data,
    output logic       DK,
    output logic       sym_start
);

    logic       w_boundary;
    logic [7:0] w_load_data;
    logic       w_load_dk;

    serdes_shift_out u_shift (
        .clk         (clk),
        .reset       (reset),
        .load_data_i (w_load_data),
        .load_dk_i   (w_load_dk),
        .boundary_o  (w_boundary),
        .data_o      (data),
        .dk_o        (DK),
        .sym_start_o (sym_start)
    );

`ifdef SERDES_SKP_INSERT_EN

    localparam logic [15:0] c_INTERVAL = 16'(SKP_INTERVAL);

    serdes_state_e state_q, state_d;
    logic [15:0]   sym_cnt_q, sym_cnt_d;
    logic [15:0]   w_cnt_inc;

    // FSM state and symbol counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SYM;
            sym_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            sym_cnt_q <= sym_cnt_d;
        end
    end

    // Source selection and ordered-set sequencing; only boundaries advance
    always_comb begin
        state_d     = state_q;
        sym_cnt_d   = sym_cnt_q;
        w_load_data = IDL;
        w_load_dk   = 1'b1;
        in_ready    = w_boundary && (state_q == SYM);
        w_cnt_inc   = sat_inc16(sym_cnt_q, c_INTERVAL);
        case (state_q)
            SYM: begin
                if (in_valid) begin
                    w_load_data = in_data;
                    w_load_dk   = in_DK;
                end
                if (w_boundary) begin
                    // The symbol loaded now completes the interval: the
                    // ordered set occupies the following four slots.
                    if (w_cnt_inc >= c_INTERVAL) begin
                        state_d   = SKP_COM;
                        sym_cnt_d = 16'd0;
                    end else begin
                        sym_cnt_d = w_cnt_inc;
                    end
                end
            end
            SKP_COM: begin
                w_load_data = COM;
                if (w_boundary) state_d = SKP_1;
            end
            SKP_1: begin
                w_load_data = SKP;
                if (w_boundary) state_d = SKP_2;
            end
            SKP_2: begin
                w_load_data = SKP;
                if (w_boundary) state_d = SKP_3;
            end
            SKP_3: begin
                w_load_data = SKP;
                if (w_boundary) state_d = SYM;
            end
            default: begin
                state_d = SYM;
            end
        endcase
    end

`else

    // Without SKP insertion every boundary accepts input or sends IDL
    always_comb begin
        in_ready    = w_boundary;
        w_load_data = IDL;
        w_load_dk   = 1'b1;
        if (in_valid) begin
            w_load_data = in_data;
            w_load_dk   = in_DK;
        end
    end

`endif

endmodule : serializador
`default_nettype wire
